// File: rtl/inv_test_sequencer.sv
// inv_test_sequencer: clocked stimulus/check sequencer for a single inverter cell.
// Drives up to 8 programmed input vectors onto dut_a, waits SETTLE_CYCLES,
// samples dut_y against ~dut_a and reports pass / error count / first failing index.
module inv_test_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [3:0] pattern_len,
  output logic       dut_a,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counter preload: SETTLE occupies exactly SETTLE_CYCLES cycles (load N-1, leave at 0).
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] last_q, last_d;   // clamped length minus one
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fidx_q, fidx_d;

  logic [3:0] len_clamp;
  logic [3:0] len_m1;
  logic       mismatch;

  assign len_clamp = (pattern_len > 4'd8) ? 4'd8 : pattern_len;
  assign len_m1    = len_clamp - 4'd1;
  // A healthy inverter output is the complement of what is being driven.
  assign mismatch  = (dut_y == dut_a_q);

  // Next-state and output-register logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dut_a_d = dut_a_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // A zero length start is dropped without touching any result register.
        if (start && (pattern_len != 4'd0)) begin
          pat_d   = pattern;
          last_d  = len_m1[2:0];
          idx_d   = 3'd0;
          err_d   = 4'd0;
          fidx_d  = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        dut_a_d = pat_q[idx_q];
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) fidx_d = idx_q;
        end
        if (idx_q == last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 4'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= 8'd0;
      last_q  <= 3'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      dut_a_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fidx_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dut_a_q <= dut_a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fidx_q;

endmodule
